lsu_ctrl: RTL and testbench

Load/store controller directly upstream of data_mem (64×32, word-addressed, async read, sync write). It accepts byte-addressed RISC-V load/store requests from the execute stage and converts them into word accesses. Sub-word stores are done as read-modify-write. Loads are byte/half extracted and sign- or zero-extended. Misaligned, out-of-range and illegal accesses are reported as errors, with no memory side effect.

---
 rtl/lsu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_ctrl.sv | 145 ++++++++++++++
 tb/tb_lsu_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store controller.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RD_MOD = 3'd2,
        S_WRITE  = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] ldata_o,
    output logic [DATA_W-1:0] merged_o
);

    logic [7:0]  byte_w;
    logic [15:0] half_w;

    always_comb begin
        byte_w = word_i[{addr_i, 3'b000} +: 8];
        half_w = addr_i[1] ? word_i[31:16] : word_i[15:0];

        ldata_o = word_i;
        case (funct3_i)
            F3_B:    ldata_o = {{24{byte_w[7]}}, byte_w};
            F3_BU:   ldata_o = {24'd0, byte_w};
            F3_H:    ldata_o = {{16{half_w[15]}}, half_w};
            F3_HU:   ldata_o = {16'd0, half_w};
            default: ldata_o = word_i;
        endcase

        merged_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                merged_o = word_i;
                merged_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
            end
            F3_H: begin
                merged_o = word_i;
                merged_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
            end
            default: merged_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Byte-addressed load/store front end for a word-wide data memory.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [2:0]        req_funct3_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_rd_en_o,
    output logic              mem_wr_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    localparam int BA_W = ADDR_W + 2;

    state_e            state_q, state_d;
    logic [2:0]        f3_q, f3_d;
    logic [BA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] ldata;
    logic [DATA_W-1:0] merged;
    logic              f3_ok;
    logic              misal;
    logic              oor;
    logic              req_err;

    always_comb begin
        if (req_we_i) begin
            f3_ok = req_funct3_i inside {F3_B, F3_H, F3_W};
        end else begin
            f3_ok = req_funct3_i inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
        end
        misal = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0])
              || ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        oor     = |req_addr_i[31:BA_W];
        req_err = !f3_ok || misal || oor;
    end

    lsu_align u_align (
        .funct3_i (f3_q),
        .addr_i   (addr_q[1:0]),
        .word_i   (mem_rdata_i),
        .wdata_i  (wdata_q),
        .ldata_o  (ldata),
        .merged_o (merged)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        merge_d     = merge_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        mem_rd_en_o = 1'b0;
        mem_wr_en_o = 1'b0;
        mem_wdata_o = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    f3_d    = req_funct3_i;
                    addr_d  = req_addr_i[BA_W-1:0];
                    wdata_d = req_wdata_i;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we_i) begin
                        state_d = S_LOAD;
                    end else if (req_funct3_i == F3_W) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RD_MOD;
                    end
                end
            end
            S_LOAD: begin
                mem_rd_en_o = 1'b1;
                rdata_d     = ldata;
                state_d     = S_RESP;
            end
            S_RD_MOD: begin
                mem_rd_en_o = 1'b1;
                merge_d     = merged;
                state_d     = S_WRITE;
            end
            S_WRITE: begin
                mem_wr_en_o = 1'b1;
                mem_wdata_o = (f3_q == F3_W) ? wdata_q : merge_q;
                state_d     = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_rdata_o = rdata_q;
    assign mem_addr_o  = addr_q[BA_W-1:2];

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural 64x32 data memory.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [2:0]  req_funct3_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic [5:0]  mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    logic [31:0] mem [64];
    logic [31:0] snap [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o];

    always @(posedge clk) begin
        if (mem_wr_en_o) mem[mem_addr_o] <= mem_wdata_o;
        else if (pre_en) mem[pre_addr] <= pre_data;
    end

    lsu_ctrl #(.ADDR_W(6)) dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_funct3_i (req_funct3_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .mem_rd_en_o  (mem_rd_en_o),
        .mem_wr_en_o  (mem_wr_en_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i)
    );

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Issue one request from IDLE and observe it until its response pulse.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int lat, output int rd, output int wr,
                           output int both, output logic [31:0] rdata,
                           output logic err);
        lat = 0; rd = 0; wr = 0; both = 0; rdata = 'x; err = 1'bx;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wd;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            rd += int'(mem_rd_en_o);
            wr += int'(mem_wr_en_o);
            both += int'(mem_rd_en_o & mem_wr_en_o);
            if (rsp_valid_o) begin
                lat = k; rdata = rsp_rdata_o; err = rsp_err_o;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        req_valid_i = 1'b0; req_we_i = 1'b0; req_funct3_i = '0;
        req_addr_i = '0; req_wdata_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o} !== 3'b100)
            $display("FAIL reset_ctl: got %b expected 100",
                     {req_ready_o, rsp_valid_o, rsp_err_o});
        else passes++;
        checks++;
        if ({mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o, rsp_rdata_o} !== '0)
            $display("FAIL reset_mem: rd=%b wr=%b addr=%h wd=%h rdata=%h expected all 0",
                     mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wdata_o, rsp_rdata_o);
        else passes++;
        rst_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_lw();
        int lat, rd, wr, both;
        logic [31:0] rdata;
        logic err;
        poke(6'd2, 32'd25);
        run_req(1'b0, 3'b010, 32'h08, 32'h0, lat, rd, wr, both, rdata, err);
        checks++;
        if (lat !== 2) $display("FAIL lw_lat: got %0d expected 2", lat);
        else passes++;
        checks++;
        if (rdata !== 32'h00000019 || err !== 1'b0)
            $display("FAIL lw_data: got %h err %b expected 00000019 err 0", rdata, err);
        else passes++;
        checks++;
        if (rd !== 1 || wr !== 0)
            $display("FAIL lw_strobes: got rd %0d wr %0d expected rd 1 wr 0", rd, wr);
        else passes++;
    endtask

    task automatic test_sw_loads();
        int lat, rd, wr, both;
        logic [31:0] rdata;
        logic err;
        logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ads [4] = '{32'h04, 32'h07, 32'h06, 32'h04};
        logic [31:0] exp [4] = '{32'hFFFFFFF3, 32'h00000080, 32'hFFFF8081, 32'h000082F3};
        run_req(1'b1, 3'b010, 32'h04, 32'h808182F3, lat, rd, wr, both, rdata, err);
        checks++;
        if (lat !== 2 || rd !== 0 || wr !== 1)
            $display("FAIL sw_timing: got lat %0d rd %0d wr %0d expected 2 0 1", lat, rd, wr);
        else passes++;
        checks++;
        if (mem[1] !== 32'h808182F3 || rdata !== 32'h0 || err !== 1'b0)
            $display("FAIL sw_word: got %h rdata %h err %b expected 808182F3 0 0",
                     mem[1], rdata, err);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            run_req(1'b0, f3s[i], ads[i], 32'h0, lat, rd, wr, both, rdata, err);
            checks++;
            if (rdata !== exp[i] || err !== 1'b0 || lat !== 2)
                $display("FAIL subload%0d: got %h err %b lat %0d expected %h 0 2",
                         i, rdata, err, lat, exp[i]);
            else passes++;
        end
    endtask

    task automatic test_sub_store();
        int lat, rd, wr, both;
        logic [31:0] rdata;
        logic err;
        poke(6'd0, 32'h00000011);
        run_req(1'b1, 3'b000, 32'h01, 32'h123456AB, lat, rd, wr, both, rdata, err);
        checks++;
        if (lat !== 3 || rd !== 1 || wr !== 1 || both !== 0)
            $display("FAIL sb_timing: got lat %0d rd %0d wr %0d both %0d expected 3 1 1 0",
                     lat, rd, wr, both);
        else passes++;
        checks++;
        if (mem[0] !== 32'h0000AB11)
            $display("FAIL sb_word: got %h expected 0000AB11", mem[0]);
        else passes++;
        run_req(1'b1, 3'b001, 32'h02, 32'h0000BEEF, lat, rd, wr, both, rdata, err);
        checks++;
        if (lat !== 3 || mem[0] !== 32'hBEEFAB11 || err !== 1'b0)
            $display("FAIL sh_word: got %h lat %0d err %b expected BEEFAB11 3 0",
                     mem[0], lat, err);
        else passes++;
    endtask

    task automatic test_errors();
        int lat, rd, wr, both, diff;
        logic [31:0] rdata;
        logic err;
        logic        wes [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3s [6] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100, 3'b001};
        logic [31:0] ads [6] = '{32'h02, 32'h03, 32'h100, 32'h00, 32'h00, 32'h05};
        // Leave a nonzero rdata behind so the error responses must clear it.
        run_req(1'b0, 3'b010, 32'h04, 32'h0, lat, rd, wr, both, rdata, err);
        for (int j = 0; j < 64; j++) snap[j] = mem[j];
        for (int i = 0; i < 6; i++) begin
            run_req(wes[i], f3s[i], ads[i], 32'hDEADBEEF, lat, rd, wr, both, rdata, err);
            checks++;
            if (lat !== 1 || err !== 1'b1 || rdata !== 32'h0 || rd !== 0 || wr !== 0)
                $display("FAIL err%0d: got lat %0d err %b rdata %h rd %0d wr %0d expected 1 1 0 0 0",
                         i, lat, err, rdata, rd, wr);
            else passes++;
        end
        diff = 0;
        for (int j = 0; j < 64; j++) if (mem[j] !== snap[j]) diff++;
        checks++;
        if (diff !== 0) $display("FAIL err_mem: got %0d changed words expected 0", diff);
        else passes++;
    endtask

    task automatic test_reset_mid();
        int pulses, writes;
        req_valid_i = 1'b1; req_we_i = 1'b1; req_funct3_i = 3'b000;
        req_addr_i = 32'h00; req_wdata_i = 32'h00000055;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        checks++;
        if (mem_rd_en_o !== 1'b1) $display("FAIL rmw_rd: got %b expected 1", mem_rd_en_o);
        else passes++;
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({req_ready_o, mem_rd_en_o, mem_wr_en_o} !== 3'b100)
            $display("FAIL rst_async: got %b expected 100",
                     {req_ready_o, mem_rd_en_o, mem_wr_en_o});
        else passes++;
        @(posedge clk); #1;
        checks++;
        if ({req_ready_o, mem_wr_en_o} !== 2'b10)
            $display("FAIL rst_hold: got %b expected 10", {req_ready_o, mem_wr_en_o});
        else passes++;
        @(negedge clk);
        rst_i = 1'b0;
        pulses = 0; writes = 0;
        repeat (6) begin
            @(negedge clk);
            pulses += int'(rsp_valid_o);
            writes += int'(mem_wr_en_o);
        end
        checks++;
        if (pulses !== 0 || writes !== 0 || mem[0] !== 32'hBEEFAB11)
            $display("FAIL rst_mid: got pulses %0d writes %0d word0 %h expected 0 0 BEEFAB11",
                     pulses, writes, mem[0]);
        else passes++;
        @(posedge clk); #1;
    endtask

    // Hold one request valid and check that accepts occur only every gap cycles.
    task automatic hold_req(input string nm, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int gap);
        int last, n, bad, both;
        last = -1; n = 0; bad = 0; both = 0;
        req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
        req_addr_i = addr; req_wdata_i = wd;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            both += int'(mem_rd_en_o & mem_wr_en_o);
            if (req_ready_o) begin
                if (last >= 0 && (i - last) != gap) bad++;
                last = i;
                n++;
            end
        end
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready_o) break;
        end
        @(posedge clk); #1;
        checks++;
        if (bad !== 0 || n !== (12 + gap - 1) / gap || both !== 0)
            $display("FAIL b2b_%s: got %0d accepts %0d bad gaps %0d overlaps expected %0d 0 0",
                     nm, n, bad, both, (12 + gap - 1) / gap);
        else passes++;
    endtask

    task automatic test_back_to_back();
        hold_req("lw", 1'b0, 3'b010, 32'h08, 32'h0, 3);
        hold_req("err", 1'b0, 3'b010, 32'h02, 32'h0, 2);
        hold_req("sb", 1'b1, 3'b000, 32'h01, 32'h000000AB, 4);
        checks++;
        if (mem[0] !== 32'hBEEFAB11 || mem[2] !== 32'd25)
            $display("FAIL b2b_mem: got %h %h expected BEEFAB11 00000019", mem[0], mem[2]);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_loads();
        test_sub_store();
        test_errors();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
